// File: rtl/fft_pkg.sv
// Shared definitions for the streaming 4-point FFT: frame size and FSM state encoding.
package fft_pkg;

  localparam int NPTS = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_LOAD   = 2'd0;
  localparam state_t ST_ST1    = 2'd1;
  localparam state_t ST_ST2    = 2'd2;
  localparam state_t ST_UNLOAD = 2'd3;

endpackage

// File: rtl/fft_bfly2.sv
// Registered radix-2 complex butterfly: sum/diff of a and b, with optional -j (dir=0)
// or +j (dir=1) rotation applied to b. The output is one bit wider than the input, so nothing overflows.
module fft_bfly2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  input  logic         i_rot,
  input  logic         i_dir,
  input  logic [W-1:0] i_ar,
  input  logic [W-1:0] i_ai,
  input  logic [W-1:0] i_br,
  input  logic [W-1:0] i_bi,
  output logic [W:0]   o_sr,
  output logic [W:0]   o_si,
  output logic [W:0]   o_dr,
  output logic [W:0]   o_di
);

  logic signed [W:0] w_ar, w_ai, w_br, w_bi;
  logic signed [W:0] w_sr, w_si, w_dr, w_di;

  assign w_ar = $signed({i_ar[W-1], i_ar});
  assign w_ai = $signed({i_ai[W-1], i_ai});
  assign w_br = $signed({i_br[W-1], i_br});
  assign w_bi = $signed({i_bi[W-1], i_bi});

  // Rotation is folded into the add/sub selection, so -b never has to be formed on its own.
  always_comb begin
    w_sr = w_ar + w_br;
    w_si = w_ai + w_bi;
    w_dr = w_ar - w_br;
    w_di = w_ai - w_bi;
    if (i_rot && !i_dir) begin
      w_sr = w_ar + w_bi;
      w_si = w_ai - w_br;
      w_dr = w_ar - w_bi;
      w_di = w_ai + w_br;
    end else if (i_rot) begin
      w_sr = w_ar - w_bi;
      w_si = w_ai + w_br;
      w_dr = w_ar + w_bi;
      w_di = w_ai - w_br;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_sr <= '0;
      o_si <= '0;
      o_dr <= '0;
      o_di <= '0;
    end else if (i_en) begin
      o_sr <= w_sr;
      o_si <= w_si;
      o_dr <= w_dr;
      o_di <= w_di;
    end
  end

endmodule

// File: rtl/fft4_stream.sv
// Streaming 4-point radix-2 DIT FFT/IFFT: serial sample load, two registered butterfly stages,
// serial bin unload under valid/ready backpressure.
module fft4_stream
  import fft_pkg::*;
#(
  parameter  int IN_W  = 32,
  localparam int OUT_W = IN_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inv,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_re,
  input  logic [IN_W-1:0]  in_im,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_re,
  output logic [OUT_W-1:0] out_im,
  output logic [1:0]       out_idx,
  output logic             out_last,
  output logic             busy
);

  state_t          r_state;
  logic [1:0]      r_cnt;
  logic [1:0]      r_idx;
  logic            r_mode;
  logic [IN_W-1:0] r_xr [NPTS];
  logic [IN_W-1:0] r_xi [NPTS];

  logic            w_in_fire;
  logic            w_out_fire;

  logic [IN_W:0]   w_a0r, w_a0i, w_a1r, w_a1i;
  logic [IN_W:0]   w_b0r, w_b0i, w_b1r, w_b1i;
  logic [OUT_W-1:0] w_y0r, w_y0i, w_y1r, w_y1i, w_y2r, w_y2i, w_y3r, w_y3i;

  assign in_ready   = (r_state == ST_LOAD);
  assign out_valid  = (r_state == ST_UNLOAD);
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign out_idx    = r_idx;
  assign out_last   = out_valid && (r_idx == 2'd3);
  assign busy       = !((r_state == ST_LOAD) && (r_cnt == 2'd0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
      r_cnt   <= 2'd0;
      r_idx   <= 2'd0;
      r_mode  <= 1'b0;
    end else begin
      case (r_state)
        ST_LOAD: begin
          if (w_in_fire) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd0) r_mode <= inv;
            if (r_cnt == 2'd3) r_state <= ST_ST1;
          end
        end
        ST_ST1: r_state <= ST_ST2;
        ST_ST2: begin
          r_state <= ST_UNLOAD;
          r_idx   <= 2'd0;
        end
        ST_UNLOAD: begin
          if (w_out_fire) begin
            r_idx <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
              r_state <= ST_LOAD;
              r_cnt   <= 2'd0;
            end
          end
        end
        default: r_state <= ST_LOAD;
      endcase
    end
  end

  // Sample buffer needs no reset: every slot is rewritten before a frame is computed.
  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r_xr[r_cnt] <= in_re;
      r_xi[r_cnt] <= in_im;
    end
  end

  fft_bfly2 #(.W(IN_W)) u_st1_even (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == ST_ST1),
    .i_rot(1'b0),
    .i_dir(1'b0),
    .i_ar (r_xr[0]),
    .i_ai (r_xi[0]),
    .i_br (r_xr[2]),
    .i_bi (r_xi[2]),
    .o_sr (w_a0r),
    .o_si (w_a0i),
    .o_dr (w_a1r),
    .o_di (w_a1i)
  );

  fft_bfly2 #(.W(IN_W)) u_st1_odd (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == ST_ST1),
    .i_rot(1'b0),
    .i_dir(1'b0),
    .i_ar (r_xr[1]),
    .i_ai (r_xi[1]),
    .i_br (r_xr[3]),
    .i_bi (r_xi[3]),
    .o_sr (w_b0r),
    .o_si (w_b0i),
    .o_dr (w_b1r),
    .o_di (w_b1i)
  );

  fft_bfly2 #(.W(IN_W + 1)) u_st2_even (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == ST_ST2),
    .i_rot(1'b0),
    .i_dir(1'b0),
    .i_ar (w_a0r),
    .i_ai (w_a0i),
    .i_br (w_b0r),
    .i_bi (w_b0i),
    .o_sr (w_y0r),
    .o_si (w_y0i),
    .o_dr (w_y2r),
    .o_di (w_y2i)
  );

  // Forward uses the -j twiddle on b1; inverse uses +j, which swaps Y1 and Y3.
  fft_bfly2 #(.W(IN_W + 1)) u_st2_odd (
    .clk  (clk),
    .rst  (rst),
    .i_en (r_state == ST_ST2),
    .i_rot(1'b1),
    .i_dir(r_mode),
    .i_ar (w_a1r),
    .i_ai (w_a1i),
    .i_br (w_b1r),
    .i_bi (w_b1i),
    .o_sr (w_y1r),
    .o_si (w_y1i),
    .o_dr (w_y3r),
    .o_di (w_y3i)
  );

  always_comb begin
    out_re = '0;
    out_im = '0;
    if (out_valid) begin
      case (r_idx)
        2'd0: begin out_re = w_y0r; out_im = w_y0i; end
        2'd1: begin out_re = w_y1r; out_im = w_y1i; end
        2'd2: begin out_re = w_y2r; out_im = w_y2i; end
        default: begin out_re = w_y3r; out_im = w_y3i; end
      endcase
    end
  end

endmodule
